// File: rtl/data_island_scheduler_pkg.sv
// hdmi_sched_pkg: channel mode encoding, island states and island timing constants.
package hdmi_sched_pkg;
  typedef enum logic [2:0] {
    CTL       = 3'd0,
    VID_PRE   = 3'd1,
    VID_GUARD = 3'd2,
    VID_DATA  = 3'd3,
    DI_PRE    = 3'd4,
    DI_GUARD  = 3'd5,
    DI_DATA   = 3'd6
  } tmds_mode_t;
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_LGUARD, S_DATA, S_TGUARD} island_state_t;
  localparam int DI_PRE_LEN = 8;
  localparam int GUARD_LEN  = 2;
  localparam int PACKET_LEN = 32;
  localparam int CTL_MIN    = 12;
endpackage

// File: rtl/data_island_scheduler_island_fsm.sv
// island_fsm: data-island state machine with packet pixel and packet counters.
module island_fsm
  import hdmi_sched_pkg::*;
#(
  parameter int BIT_WIDTH    = 10,
  parameter int FRAME_WIDTH  = 800,
  parameter int SCREEN_WIDTH = 640,
  parameter int MAX_PACKETS  = 18
) (
  input  logic                 clk_pixel,
  input  logic                 reset_n,
  input  logic [BIT_WIDTH-1:0] cx,
  input  logic                 hold_idle,
  output logic [2:0]           island_mode,
  output logic                 packet_enable,
  output logic [4:0]           packet_pixel_counter,
  output logic                 island_overrun
);
  localparam int W1 = BIT_WIDTH + 1;
  localparam logic [W1-1:0] WIN_START = W1'(SCREEN_WIDTH + 4);
  localparam logic [W1-1:0] VP_START  = W1'(FRAME_WIDTH - 10);
  localparam logic [W1-1:0] LIMIT     = W1'(FRAME_WIDTH - 10 - CTL_MIN);
  localparam logic [W1-1:0] TAIL      = W1'(PACKET_LEN + GUARD_LEN);
  localparam bit ROOM = (SCREEN_WIDTH + 4 + DI_PRE_LEN + 2 * GUARD_LEN + PACKET_LEN)
                        <= (FRAME_WIDTH - 10 - CTL_MIN);
  island_state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d, pkt_q, pkt_d;
  logic pe_q, pe_d, ovr_q, ovr_d;
  logic [W1-1:0] x, p;
  assign x = {1'b0, cx};
  assign p = x + W1'(1);
  // Registers describe the pixel currently on the outputs; *_d describe the sampled cx.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 5'd1;
    pkt_d   = pkt_q;
    ovr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (x == WIN_START && ROOM && !hold_idle) state_d = S_PRE;
      end
      S_PRE: if (cnt_q == 5'(DI_PRE_LEN - 1)) begin
        state_d = S_LGUARD;
        cnt_d   = '0;
      end
      S_LGUARD: if (cnt_q == 5'(GUARD_LEN - 1)) begin
        state_d = S_DATA;
        cnt_d   = '0;
        pkt_d   = 5'd1;
      end
      S_DATA: if (cnt_q == 5'(PACKET_LEN - 1)) begin
        cnt_d = '0;
        if (pe_q) pkt_d = pkt_q + 5'd1;
        else state_d = S_TGUARD;
      end
      S_TGUARD: if (cnt_q == 5'(GUARD_LEN - 1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    pe_d = (state_d == S_LGUARD && cnt_d == 5'(GUARD_LEN - 1)) ||
           (state_d == S_DATA && cnt_d == 5'(PACKET_LEN - 1) &&
            pkt_d < 5'(MAX_PACKETS) && p + TAIL <= LIMIT);
    if (x == VP_START && state_d != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pe_d    = 1'b0;
      ovr_d   = 1'b1;
    end
  end
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pkt_q   <= '0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      pe_q    <= pe_d;
      ovr_q   <= ovr_d;
    end
  assign island_mode = state_d == S_PRE ? DI_PRE :
                       (state_d == S_LGUARD || state_d == S_TGUARD) ? DI_GUARD :
                       state_d == S_DATA ? DI_DATA : CTL;
  assign packet_enable        = pe_q;
  assign island_overrun       = ovr_q;
  assign packet_pixel_counter = state_q == S_DATA ? cnt_q : 5'd0;
endmodule

// File: rtl/data_island_scheduler.sv
// data_island_scheduler: HDMI video-period decode plus one data island per line.
// Optional DISCHED_DVI_FALLBACK_EN adds dvi_mode, which suppresses new islands.
module data_island_scheduler
  import hdmi_sched_pkg::*;
#(
  parameter int BIT_WIDTH     = 10,
  parameter int BIT_HEIGHT    = 10,
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int MAX_PACKETS   = 18
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
`ifdef DISCHED_DVI_FALLBACK_EN
  input  logic                  dvi_mode,
`endif
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  output logic [2:0]            mode,
  output logic                  packet_enable,
  output logic [4:0]            packet_pixel_counter,
  output logic                  video_field_end,
  output logic                  island_overrun
);
  localparam int W1 = BIT_WIDTH + 1;
  localparam int H1 = BIT_HEIGHT + 1;
  localparam logic [W1-1:0] VP_START = W1'(FRAME_WIDTH - 10);
  localparam logic [W1-1:0] VP_END   = W1'(FRAME_WIDTH - 3);
  localparam logic [W1-1:0] VG_START = W1'(FRAME_WIDTH - 2);
  localparam logic [W1-1:0] VG_END   = W1'(FRAME_WIDTH - 1);
  localparam logic [W1-1:0] SW       = W1'(SCREEN_WIDTH);
  localparam logic [H1-1:0] SH       = H1'(SCREEN_HEIGHT);
  logic [W1-1:0] x;
  logic [H1-1:0] y;
  logic [2:0] island_mode, mode_d, mode_q;
  logic hold_idle, next_act, vfe_d, vfe_q;
  assign x = {1'b0, cx};
  assign y = {1'b0, cy};
`ifdef DISCHED_DVI_FALLBACK_EN
  assign hold_idle = dvi_mode;
`else
  assign hold_idle = 1'b0;
`endif
  island_fsm #(
    .BIT_WIDTH   (BIT_WIDTH),
    .FRAME_WIDTH (FRAME_WIDTH),
    .SCREEN_WIDTH(SCREEN_WIDTH),
    .MAX_PACKETS (MAX_PACKETS)
  ) u_fsm (
    .clk_pixel           (clk_pixel),
    .reset_n             (reset_n),
    .cx                  (cx),
    .hold_idle           (hold_idle),
    .island_mode         (island_mode),
    .packet_enable       (packet_enable),
    .packet_pixel_counter(packet_pixel_counter),
    .island_overrun      (island_overrun)
  );
  // The preamble announces the next line, so it keys off the following cy.
  always_comb begin
    next_act = y == H1'(FRAME_HEIGHT - 1) || y < H1'(SCREEN_HEIGHT - 1);
    mode_d   = next_act && x >= VP_START && x <= VP_END ? VID_PRE :
               next_act && x >= VG_START && x <= VG_END ? VID_GUARD :
               x < SW && y < SH ? VID_DATA : island_mode;
    vfe_d    = x == SW - W1'(1) && y == SH - H1'(1);
  end
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) begin
      mode_q <= CTL;
      vfe_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      vfe_q  <= vfe_d;
    end
  assign mode            = mode_q;
  assign video_field_end = vfe_q;
endmodule

// File: tb/tb_data_island_scheduler.sv
// tb_data_island_scheduler: directed lines on default, two-packet and no-room builds,
// expectations queued at drive time and compared one pixel later.
module tb_data_island_scheduler;
  import hdmi_sched_pkg::*;
  typedef struct packed {
    logic [2:0] m;
    logic       pe;
    logic [4:0] ppc;
    logic       ov;
    logic       vfe;
  } o_t;
  typedef struct {
    int x;
    o_t a;
    o_t b;
    o_t c;
  } ent_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic dvi_mode = 1'b0;
  logic [9:0] cx = '0, cy = '0, cx2 = '0, cy2 = '0;
  logic [2:0] m0, m1, m2;
  logic pe0, pe1, pe2, ov0, ov1, ov2, vf0, vf1, vf2;
  logic [4:0] pp0, pp1, pp2;
  ent_t q[$];
  int n_cmp = 0, n_mis = 0, pc0 = 0, pc1 = 0, fx = 0, fy = 476;
  always #5 clk = ~clk;
  data_island_scheduler dut (
    .clk_pixel(clk), .reset_n(reset_n),
`ifdef DISCHED_DVI_FALLBACK_EN
    .dvi_mode(dvi_mode),
`endif
    .cx(cx), .cy(cy), .mode(m0), .packet_enable(pe0), .packet_pixel_counter(pp0),
    .video_field_end(vf0), .island_overrun(ov0));
  data_island_scheduler #(.MAX_PACKETS(2)) dut_mp (
    .clk_pixel(clk), .reset_n(reset_n),
`ifdef DISCHED_DVI_FALLBACK_EN
    .dvi_mode(dvi_mode),
`endif
    .cx(cx), .cy(cy), .mode(m1), .packet_enable(pe1), .packet_pixel_counter(pp1),
    .video_field_end(vf1), .island_overrun(ov1));
  data_island_scheduler #(.FRAME_WIDTH(700)) dut_fw (
    .clk_pixel(clk), .reset_n(reset_n),
`ifdef DISCHED_DVI_FALLBACK_EN
    .dvi_mode(dvi_mode),
`endif
    .cx(cx2), .cy(cy2), .mode(m2), .packet_enable(pe2), .packet_pixel_counter(pp2),
    .video_field_end(vf2), .island_overrun(ov2));
  function automatic o_t exp_o(int x, int y, bit isl, int dend, int fw);
    o_t o;
    bit na = (y == 524) || (y < 479);
    o.m = na && x >= fw - 10 && x <= fw - 3 ? VID_PRE :
          na && x >= fw - 2 ? VID_GUARD :
          x < 640 && y < 480 ? VID_DATA :
          isl && x >= 644 && x <= 651 ? DI_PRE :
          isl && (x == 652 || x == 653 || x == dend + 1 || x == dend + 2) ? DI_GUARD :
          isl && x >= 654 && x <= dend ? DI_DATA : CTL;
    o.pe  = isl && (x == 653 || (x >= 685 && x < dend && (x - 685) % 32 == 0));
    o.ppc = isl && x >= 654 && x <= dend ? 5'((x - 654) % 32) : 5'd0;
    o.ov  = 1'b0;
    o.vfe = x == 639 && y == 479;
    return o;
  endfunction
  task automatic chk(input string t, input int x, input logic [7:0] o, input logic [7:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s cx=%0d observed=%0d expected=%0d", t, x, o, e);
    end
  endtask
  task automatic cmp(input string t, input int x, input o_t o, input o_t e);
    chk({t, ".mode"}, x, 8'(o.m), 8'(e.m));
    chk({t, ".packet_enable"}, x, 8'(o.pe), 8'(e.pe));
    chk({t, ".pixel_counter"}, x, 8'(o.ppc), 8'(e.ppc));
    chk({t, ".overrun"}, x, 8'(o.ov), 8'(e.ov));
    chk({t, ".field_end"}, x, 8'(o.vfe), 8'(e.vfe));
  endtask
  task automatic check_all(input string t, input int x, input o_t ea, input o_t eb, input o_t ec);
    cmp({t, ".dflt"}, x, {m0, pe0, pp0, ov0, vf0}, ea);
    cmp({t, ".maxp2"}, x, {m1, pe1, pp1, ov1, vf1}, eb);
    cmp({t, ".fw700"}, x, {m2, pe2, pp2, ov2, vf2}, ec);
  endtask
  task automatic pop_check();
    ent_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    pc0 += int'(pe0);
    pc1 += int'(pe1);
    check_all("px", e.x, e.a, e.b, e.c);
  endtask
  task automatic step(input int x, input int y, input bit isl, input bit jump);
    ent_t e;
    @(posedge clk);
    #1;
    pop_check();
    cx  = 10'(x);
    cy  = 10'(y);
    cx2 = 10'(fx);
    cy2 = 10'(fy);
    e.x = x;
    e.a = exp_o(x, y, isl, 749, 800);
    e.b = exp_o(x, y, isl, 717, 800);
    e.c = exp_o(fx, fy, 1'b0, 0, 700);
    e.a.ov = jump;
    e.b.ov = jump;
    q.push_back(e);
    fy = fx == 699 ? (fy == 524 ? 0 : fy + 1) : fy;
    fx = fx == 699 ? 0 : fx + 1;
  endtask
  task automatic run_line(input int y, input bit isl);
    pc0 = 0;
    pc1 = 0;
    for (int x = 0; x < 800; x++) step(x, y, isl, 1'b0);
    @(posedge clk);
    #1;
    pop_check();
    chk("pe_count.dflt", y, 8'(pc0), isl ? 8'd3 : 8'd0);
    chk("pe_count.maxp2", y, 8'(pc1), isl ? 8'd2 : 8'd0);
  endtask
  initial begin
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, '0, '0, '0);
    reset_n = 1'b1;
    run_line(10, 1'b1);
    run_line(479, 1'b1);
    run_line(500, 1'b1);
    run_line(524, 1'b1);
    for (int x = 600; x < 670; x++) step(x, 10, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    pop_check();
    reset_n = 1'b0;
    cx = 10'd670;
    #1;
    check_all("reset_mid", 670, '0, '0, '0);
    #3 reset_n = 1'b1;
    for (int x = 671; x < 800; x++) step(x, 10, 1'b0, 1'b0);
    run_line(11, 1'b1);
    for (int x = 600; x <= 700; x++) step(x, 10, 1'b1, 1'b0);
    step(790, 10, 1'b1, 1'b1);
    for (int x = 791; x < 800; x++) step(x, 10, 1'b1, 1'b0);
`ifdef DISCHED_DVI_FALLBACK_EN
    dvi_mode = 1'b1;
    run_line(12, 1'b0);
    run_line(479, 1'b0);
    dvi_mode = 1'b0;
    run_line(13, 1'b1);
`endif
    @(posedge clk);
    #1;
    pop_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/data_island_scheduler.md
Name: data_island_scheduler

Overview:
- Sequences HDMI data islands inside horizontal blanking, one island per line.
- Drives the packet picker (`packet_enable`, `packet_pixel_counter`, `video_field_end`) and the TMDS channel mode select (control / video preamble / guard / data).
- Sits between the cx/cy timing generator and the packet picker plus TMDS encoders.
- Outputs are registered: one clk_pixel of latency relative to the sampled cx/cy.

Parameters:
- BIT_WIDTH, 10, width of cx
- BIT_HEIGHT, 10, width of cy
- FRAME_WIDTH, 800, total pixels per line
- FRAME_HEIGHT, 525, total lines per frame
- SCREEN_WIDTH, 640, active pixels per line
- SCREEN_HEIGHT, 480, active lines
- MAX_PACKETS, 18, maximum packets per island (1..18)

Ports:
- clk_pixel  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- cx  in  BIT_WIDTH  current pixel column
- cy  in  BIT_HEIGHT  current line
- mode  out  3  channel mode (encoding in package)
- packet_enable  out  1  one-cycle strobe: picker selects next packet
- packet_pixel_counter  out  5  pixel index within current packet
- video_field_end  out  1  one-cycle strobe at last active pixel of field
- island_overrun  out  1  one-cycle strobe: island aborted by video preamble

Behaviour:
- Reset (async assert, sync release) forces mode=CTL, all strobes 0, counter 0, state IDLE. Assertion mid-island aborts immediately; scheduling resumes at the next window start.
- Constants:
  - WIN_START = SCREEN_WIDTH+4
  - VP_START = FRAME_WIDTH-10
  - LIMIT = VP_START-12, so at least 12 control pixels precede the video preamble.
- Video path, independent of island FSM:
  - Next line active means cy==FRAME_HEIGHT-1 or cy<SCREEN_HEIGHT-1.
  - On such lines: mode=VID_PRE for cx in [VP_START, FRAME_WIDTH-3], mode=VID_GUARD for [FRAME_WIDTH-2, FRAME_WIDTH-1].
  - mode=VID_DATA when cx<SCREEN_WIDTH && cy<SCREEN_HEIGHT.
  - video_field_end=1 when cx==SCREEN_WIDTH-1 && cy==SCREEN_HEIGHT-1.
- Island FSM states: IDLE, DI_PRE (8 cycles), DI_LGUARD (2), DI_DATA (32 per packet), DI_TGUARD (2).
  - IDLE->DI_PRE at cx==WIN_START, only if WIN_START+44 <= LIMIT (room for overhead plus one packet). Otherwise no island on that line.
  - DI_PRE->DI_LGUARD after 8 cycles.
  - DI_LGUARD->DI_DATA after 2 cycles. packet_enable=1 on the second guard cycle.
  - In DI_DATA, packet_pixel_counter counts 0..31 and a packet counter counts 1..MAX_PACKETS.
  - At counter==31, with p = cx of the next pixel: if packets_sent<MAX_PACKETS && p+34<=LIMIT, assert packet_enable and remain in DI_DATA with the counter wrapping to 0. Otherwise go to DI_TGUARD.
  - DI_TGUARD->IDLE after 2 cycles.
- packet_pixel_counter is 0 outside DI_DATA. The mode output is DI_PRE, DI_GUARD or DI_DATA per the island state, and CTL otherwise.
- Islands are permitted on every line, including vertical-blanking lines.
- Simultaneous events / priority:
  - Video preamble/guard/data mode overrides island mode.
  - If cx==VP_START while the FSM is not IDLE, the FSM goes to IDLE, island_overrun pulses once, and packet_enable stays low.
  - cx reaching FRAME_WIDTH-1 wraps with no special handling. The counters are internal and independent of cx arithmetic except for the start and limit compares.
- All compares use BIT_WIDTH+1-bit unsigned arithmetic, so p+34 cannot overflow.

Optional Feature:
- Macro DISCHED_DVI_FALLBACK_EN.
- When defined: adds input port `dvi_mode` (1 bit). While dvi_mode=1, IDLE never leaves; packet_enable and island_overrun stay 0. The video path is unchanged and video_field_end still pulses. A toggle takes effect only at the next IDLE->DI_PRE decision; an island in flight always completes.
- When undefined: no port; islands are always scheduled.

Decomposition:
- Package hdmi_sched_pkg:
  - mode enum tmds_mode_t (3 bits): CTL=0, VID_PRE=1, VID_GUARD=2, VID_DATA=3, DI_PRE=4, DI_GUARD=5, DI_DATA=6.
  - Constants DI_PRE_LEN=8, GUARD_LEN=2, PACKET_LEN=32, CTL_MIN=12.
  - Island state enum.
- One sub-module: island_fsm (island states plus counters). The top module holds the video-path decode and output registers.

Test Plan:
- 640x480 defaults, line cy=10:
  - mode DI_PRE for cx 644..651 (registered, seen one cycle later); DI_GUARD 652..653; DI_DATA 654..749.
  - Exactly 3 packet_enable pulses (at cx 653, 685, 717); DI_GUARD 750..751; VID_PRE 790..797.
- MAX_PACKETS=2, same timing -> 2 packets; trailing guard at 718..719; 2 packet_enable pulses.
- FRAME_WIDTH=700 (WIN_START+44 > LIMIT=678) -> no island on any line; mode CTL throughout blanking except video preamble/guard.
- reset_n low at cx=670 mid-packet -> mode=CTL and packet_pixel_counter=0 within the same cycle. Release -> next island at cx=644 of the following line.
- Force cx jump to 790 during DI_DATA -> island_overrun pulses once, mode=VID_PRE, FSM IDLE.
- cx=639, cy=479 -> video_field_end high for exactly one cycle per frame. With DISCHED_DVI_FALLBACK_EN and dvi_mode=1 -> zero packet_enable pulses over a full frame.
